// File: rtl/wb_ps2.sv
// PS/2 device-to-host receiver with a Wishbone slave register interface.
// Pins are synchronised and the clock is deglitched. Falling edges of the filtered
// clock sample 11-bit frames, and good bytes are queued in a FIFO.
// Ports:
//   clk_i, rstn          system clock, asynchronous active-low reset
//   cyc_i, stb_i, we_i   Wishbone cycle/strobe/write enable
//   adr_i [1:0]          word address: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved
//   sel_i [3:0]          byte select (unused, full-word accesses only)
//   dat_i/dat_o [31:0]   write/read data; dat_o is 0 whenever ack_o is low
//   ack_o                single-cycle acknowledge
//   irq                  level interrupt (irq_en & FIFO non-empty)
//   ps2_clk, ps2_dat     asynchronous PS/2 pins, input only
module wb_ps2 #(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned TIMEOUT    = 50000,
   parameter int unsigned CLK_FILTER = 4
) (
   input  logic        clk_i,
   input  logic        rstn,
   input  logic        cyc_i,
   input  logic        stb_i,
   input  logic        we_i,
   input  logic [1:0]  adr_i,
   input  logic [3:0]  sel_i,
   input  logic [31:0] dat_i,
   output logic        ack_o,
   output logic [31:0] dat_o,
   output logic        irq,
   input  logic        ps2_clk,
   input  logic        ps2_dat
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam int unsigned FW = $clog2(CLK_FILTER + 1);

   typedef enum logic {StIdle, StRx} rx_state_e;

   logic unused_in;
   assign unused_in = ^{sel_i, dat_i[31:5]};

   // ---------------- input conditioning ----------------
   logic [1:0]    clk_sync_q, dat_sync_q;
   logic          clk_filt_q;
   logic [FW-1:0] filt_cnt_q;
   logic          filt_flip, sample, rx_bit;

   // Flip on the CLK_FILTER-th consecutive sample that disagrees with the filtered level.
   assign filt_flip = (clk_sync_q[1] != clk_filt_q) && (filt_cnt_q == FW'(CLK_FILTER - 1));
   assign sample    = filt_flip & clk_filt_q;
   assign rx_bit    = dat_sync_q[1];

   always_ff @(posedge clk_i or negedge rstn) begin
      if (!rstn) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
         clk_filt_q <= 1'b1;
         filt_cnt_q <= '0;
      end else begin
         clk_sync_q <= {clk_sync_q[0], ps2_clk};
         dat_sync_q <= {dat_sync_q[0], ps2_dat};
         if (clk_sync_q[1] == clk_filt_q) begin
            filt_cnt_q <= '0;
         end else if (filt_flip) begin
            clk_filt_q <= ~clk_filt_q;
            filt_cnt_q <= '0;
         end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
         end
      end
   end

   // ---------------- registers shared by FSM / FIFO / bus ----------------
   logic          rx_en_q, irq_en_q;
   logic          ovf_q, par_q, frm_q;
   logic [5:0]    count_q;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [7:0]    mem [FIFO_DEPTH];

   // ---------------- receiver FSM ----------------
   rx_state_e     state_q, state_d;
   logic [3:0]    bitcnt_q, bitcnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          parity_q, parity_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          push, set_par, set_frm;

   always_ff @(posedge clk_i or negedge rstn) begin
      if (!rstn) begin
         state_q  <= StIdle;
         bitcnt_q <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         tmo_q    <= tmo_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      tmo_d    = tmo_q;
      push     = 1'b0;
      set_par  = 1'b0;
      set_frm  = 1'b0;
      if (!rx_en_q) begin
         // Disabling drops any partial frame silently.
         state_d = StIdle;
         tmo_d   = '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (sample) begin
                  if (!rx_bit) begin
                     state_d  = StRx;
                     bitcnt_d = 4'd1;
                     tmo_d    = '0;
                  end else begin
                     set_frm = 1'b1;
                  end
               end
            end
            StRx: begin
               if (sample) begin
                  tmo_d = '0;
                  if (bitcnt_q <= 4'd8) begin
                     shift_d  = {rx_bit, shift_q[7:1]};
                     bitcnt_d = bitcnt_q + 4'd1;
                  end else if (bitcnt_q == 4'd9) begin
                     parity_d = rx_bit;
                     bitcnt_d = 4'd10;
                  end else begin
                     state_d = StIdle;
                     set_par = ~(^{shift_q, parity_q});
                     set_frm = ~rx_bit;
                     push    = (^{shift_q, parity_q}) & rx_bit;
                  end
               end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                  state_d = StIdle;
                  set_frm = 1'b1;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // ---------------- Wishbone + FIFO ----------------
   logic        ack_d, rd_en, wr_en, non_empty, full, pop, push_ok, ovf_set;
   logic [2:0]  w1c;
   logic [31:0] status, rd_data;

   assign ack_d     = cyc_i & stb_i & ~ack_o;
   assign rd_en     = ack_d & ~we_i;
   assign wr_en     = ack_d & we_i;
   assign non_empty = (count_q != 6'd0);
   assign full      = (count_q == 6'(FIFO_DEPTH));
   assign pop       = rd_en && (adr_i == 2'd0) && non_empty;
   // A simultaneous pop frees a slot, so a push into a full FIFO still succeeds.
   assign push_ok   = push & (~full | pop);
   assign ovf_set   = push & full & ~pop;
   assign w1c       = (wr_en && adr_i == 2'd1) ? dat_i[4:2] : 3'b000;
   assign status    = {18'b0, count_q, 3'b0, frm_q, par_q, ovf_q, full, non_empty};

   always_comb begin
      rd_data = '0;
      case (adr_i)
         2'd0:    rd_data = non_empty ? {23'b0, 1'b1, mem[rd_ptr_q]} : 32'b0;
         2'd1:    rd_data = status;
         2'd2:    rd_data = {30'b0, irq_en_q, rx_en_q};
         default: rd_data = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem[wr_ptr_q] <= shift_q;
   end

   always_ff @(posedge clk_i or negedge rstn) begin
      if (!rstn) begin
         ack_o    <= 1'b0;
         dat_o    <= '0;
         irq      <= 1'b0;
         rx_en_q  <= 1'b0;
         irq_en_q <= 1'b0;
         ovf_q    <= 1'b0;
         par_q    <= 1'b0;
         frm_q    <= 1'b0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         ack_o <= ack_d;
         dat_o <= rd_en ? rd_data : 32'b0;
         irq   <= irq_en_q & non_empty;
         if (wr_en && adr_i == 2'd2) begin
            rx_en_q  <= dat_i[0];
            irq_en_q <= dat_i[1];
         end
         // Set beats a same-cycle W1C clear.
         ovf_q <= (ovf_q & ~w1c[0]) | ovf_set;
         par_q <= (par_q & ~w1c[1]) | set_par;
         frm_q <= (frm_q & ~w1c[2]) | set_frm;
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push_ok && !pop)      count_q <= count_q + 6'd1;
         else if (pop && !push_ok) count_q <= count_q - 6'd1;
      end
   end

endmodule

// File: tb/tb_wb_ps2.sv
module tb_wb_ps2;

   localparam int HP = 15;  // PS/2 half period in system clocks

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [1:0]  adr = 2'd0;
   logic [3:0]  sel = 4'hF;
   logic [31:0] dat_w = '0;
   logic        ack;
   logic [31:0] dat_r;
   logic        irq;
   logic        ps2_clk = 1'b1, ps2_dat = 1'b1;

   int          total = 0, bad = 0;
   logic [31:0] rd, popped;

   wb_ps2 #(.FIFO_DEPTH(16), .TIMEOUT(50000), .CLK_FILTER(4)) dut (
      .clk_i(clk), .rstn(rstn), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr),
      .sel_i(sel), .dat_i(dat_w), .ack_o(ack), .dat_o(dat_r), .irq(irq),
      .ps2_clk(ps2_clk), .ps2_dat(ps2_dat)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
      tick(1);
      d = dat_r;
      chk("read_ack", {31'b0, ack}, 32'd1);
      cyc = 1'b0; stb = 1'b0;
      tick(1);
   endtask

   task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d;
      tick(1);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      tick(1);
   endtask

   // mode 0: plain bit, 1: 2-cycle low glitch in the high phase, 2: DATA read on the sample cycle
   task automatic send_bit(input logic b, input int mode);
      ps2_dat = b;
      if (mode == 1) begin
         tick(4); ps2_clk = 1'b0; tick(2); ps2_clk = 1'b1; tick(HP - 6);
      end else begin
         tick(HP);
      end
      ps2_clk = 1'b0;
      if (mode == 2) begin
         // sync (2) + filter (4) puts the sample strobe on the 6th rising edge
         tick(5);
         cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd0;
         tick(1);
         popped = dat_r;
         cyc = 1'b0; stb = 1'b0;
         tick(HP - 6);
      end else begin
         tick(HP);
      end
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic stop,
                             input logic pop_at_stop, input int glitch_bit);
      send_bit(1'b0, 0);
      for (int i = 0; i < 8; i++) send_bit(b[i], (glitch_bit == i + 1) ? 1 : 0);
      send_bit((~^b) ^ ~par_ok, 0);
      send_bit(stop, pop_at_stop ? 2 : 0);
      tick(HP);
   endtask

   initial begin
      // reset state
      #2 rstn = 1'b0;
      #3;
      chk("rst_ack", {31'b0, ack}, 32'd0);
      chk("rst_dat", dat_r, 32'd0);
      chk("rst_irq", {31'b0, irq}, 32'd0);
      tick(3);
      rstn = 1'b1;
      tick(1);
      wb_read(2'd1, rd); chk("rst_status", rd, 32'h0);
      wb_read(2'd2, rd); chk("rst_ctrl", rd, 32'h0);
      wb_write(2'd2, 32'h3);
      wb_read(2'd2, rd); chk("ctrl_rb", rd, 32'h3);
      wb_read(2'd3, rd); chk("reserved", rd, 32'h0);

      // good frame 0x1C
      send_frame(8'h1C, 1'b1, 1'b1, 1'b0, -1);
      tick(2);
      chk("irq_rise", {31'b0, irq}, 32'd1);
      wb_read(2'd1, rd); chk("st_one", rd, 32'h101);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd0;
      tick(1);
      chk("data_1c", dat_r, 32'h11C);
      chk("irq_at_pop", {31'b0, irq}, 32'd1);
      cyc = 1'b0; stb = 1'b0;
      tick(1);
      chk("irq_fall", {31'b0, irq}, 32'd0);
      wb_read(2'd1, rd); chk("st_empty", rd, 32'h0);

      // parity error, then stop-bit error
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0, -1);
      wb_read(2'd1, rd); chk("st_par", rd, 32'h8);
      wb_write(2'd1, 32'h8);
      wb_read(2'd1, rd); chk("st_par_clr", rd, 32'h0);
      send_frame(8'h1C, 1'b1, 1'b0, 1'b0, -1);
      wb_read(2'd1, rd); chk("st_frm", rd, 32'h10);
      wb_write(2'd1, 32'h10);
      wb_read(2'd1, rd); chk("st_frm_clr", rd, 32'h0);

      // fill, push+pop while full, overflow, drain
      for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, 1'b1, 1'b0, -1);
      wb_read(2'd1, rd); chk("st_full", rd, 32'h1003);
      send_frame(8'h10, 1'b1, 1'b1, 1'b1, -1);
      chk("pop_at_push", popped, 32'h100);
      wb_read(2'd1, rd); chk("st_full_nopovf", rd, 32'h1003);
      send_frame(8'h11, 1'b1, 1'b1, 1'b0, -1);
      wb_read(2'd1, rd); chk("st_ovf", rd, 32'h1007);
      for (int i = 1; i <= 16; i++) begin
         wb_read(2'd0, rd);
         chk($sformatf("drain_%0d", i), rd, 32'h100 | 32'(i));
      end
      wb_read(2'd0, rd); chk("drain_empty", rd, 32'h0);
      wb_read(2'd1, rd); chk("st_ovf_sticky", rd, 32'h4);
      wb_write(2'd1, 32'h4);
      wb_read(2'd1, rd); chk("st_ovf_clr", rd, 32'h0);

      // timeout after 5 bits
      send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
      send_bit(1'b1, 0); send_bit(1'b1, 0);
      tick(48000);
      wb_read(2'd1, rd); chk("tmo_early", rd, 32'h0);
      tick(3000);
      wb_read(2'd1, rd); chk("tmo_frm", rd, 32'h10);
      wb_write(2'd1, 32'h10);
      send_frame(8'hAA, 1'b1, 1'b1, 1'b0, -1);
      wb_read(2'd0, rd); chk("data_aa", rd, 32'h1AA);
      wb_read(2'd1, rd); chk("st_after_aa", rd, 32'h0);

      // glitch on ps2_clk mid-frame
      send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 4);
      wb_read(2'd0, rd); chk("data_5a", rd, 32'h15A);
      wb_read(2'd1, rd); chk("st_glitch", rd, 32'h0);

      // reset mid-frame with bytes queued and an ack in flight
      send_frame(8'h01, 1'b1, 1'b1, 1'b0, -1);
      send_frame(8'h02, 1'b1, 1'b1, 1'b0, -1);
      send_frame(8'h03, 1'b1, 1'b1, 1'b0, -1);
      send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
      chk("irq_before_rst", {31'b0, irq}, 32'd1);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd1;
      @(posedge clk); #1;
      chk("ack_before_rst", {31'b0, ack}, 32'd1);
      rstn = 1'b0;
      #1;
      chk("mid_rst_ack", {31'b0, ack}, 32'd0);
      chk("mid_rst_dat", dat_r, 32'h0);
      chk("mid_rst_irq", {31'b0, irq}, 32'd0);
      cyc = 1'b0; stb = 1'b0;
      tick(2);
      rstn = 1'b1;
      tick(1);
      wb_read(2'd1, rd); chk("post_rst_status", rd, 32'h0);
      wb_read(2'd2, rd); chk("post_rst_ctrl", rd, 32'h0);
      wb_write(2'd2, 32'h3);
      send_frame(8'h3C, 1'b1, 1'b1, 1'b0, -1);
      wb_read(2'd0, rd); chk("data_3c", rd, 32'h13C);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_ps2.md
Name: wb_ps2

Overview:
- Wishbone slave in the peripheral arbiter space; receives keyboard/mouse scan codes on the board PS/2 pins (ps2_clk, ps2_dat, device-to-host only).
- Path: pins → deglitched clock-edge detector → 11-bit frame receiver → byte FIFO → Wishbone registers.
- Level interrupt output feeds one irqc input line.
- Host-to-device transmission is out of scope; both pins are inputs only.

Parameters:
- FIFO_DEPTH, 16: FIFO entries. Power of two, 2..32.
- TIMEOUT, 50000: clk_i cycles without a PS/2 falling edge before a partial frame is aborted.
- CLK_FILTER, 4: consecutive identical synced samples required before the filtered PS/2 clock changes level.

Ports:
- clk_i, input, 1: system clock (sys_clk).
- rstn, input, 1: reset, asynchronous, active-low.
- cyc_i, input, 1: Wishbone cycle.
- stb_i, input, 1: Wishbone strobe, decoded slot select.
- we_i, input, 1: write enable.
- adr_i, input, 2: word address. 0 = DATA, 1 = STATUS, 2 = CTRL, 3 = reserved.
- sel_i, input, 4: byte select; ignored, all accesses are full-word.
- dat_i, input, 32: write data.
- ack_o, output, 1: single-cycle acknowledge.
- dat_o, output, 32: read data.
- irq, output, 1: level interrupt to irqc.
- ps2_clk, input, 1: PS/2 clock pin, asynchronous.
- ps2_dat, input, 1: PS/2 data pin, asynchronous.

Behaviour:
- Reset values (rstn low, asynchronous): ack_o = 0, dat_o = 0, irq = 0, CTRL = 0, FIFO empty, sticky flags 0, FSM IDLE. Synchronizers and filter reset to 1.
- Input conditioning:
  - Each pin passes through a 2-flop synchronizer.
  - Filtered clock flips only after CLK_FILTER consecutive synced samples disagree with its current level.
  - A falling edge of the filtered clock raises a one-cycle sample strobe; the synced data is captured on that cycle.
- Wishbone:
  - ack_o <= cyc_i & stb_i & ~ack_o, so latency is 1 cycle and ack_o is never asserted two cycles in a row.
  - Register side effects occur exactly once, on the cycle ack_o is driven high.
  - dat_o is registered alongside ack_o and is 0 whenever ack_o = 0.
- DATA (RO):
  - Read returns {23'b0, 1, byte} and pops the FIFO if it is non-empty.
  - Read when empty returns 0 and does not pop.
  - Writes are ignored.
- STATUS:
  - [0] non-empty, [1] full, [2] overflow (sticky), [3] parity error (sticky), [4] framing error (sticky), [13:8] entry count, all other bits 0.
  - Writing 1 to bits 2–4 clears them (W1C).
  - A sticky set and a W1C clear in the same cycle: set wins.
- CTRL (RW): [0] rx_en, [1] irq_en. Other bits read 0.
- Reserved address: reads 0, writes ignored, still acknowledged.
- Receiver FSM, states IDLE and RX, advancing on sample strobes only:
  - IDLE, start bit 0: go to RX, bitcnt = 1, timeout counter cleared.
  - IDLE, start bit 1: set framing error, stay in IDLE.
  - RX bits 1–8: data bits, LSB first, shifted into the byte register.
  - RX bit 9: parity bit. Odd parity is required: XOR of the 8 data bits and the parity bit must be 1.
  - RX bit 10: stop bit, must be 1.
  - On bit 10: parity and stop both good → push byte. Otherwise set parity error (parity bad) and/or framing error (stop = 0), and discard the byte. Return to IDLE in all cases.
  - Timeout: in RX, the counter increments every cycle and clears on each strobe. Reaching TIMEOUT → go to IDLE, set framing error, discard the partial frame.
  - rx_en = 0: FSM forced to IDLE, strobes ignored. FIFO contents and flags are kept. Clearing rx_en mid-frame drops that frame without flagging it.
- FIFO:
  - Push while full: byte dropped, overflow set, FIFO unchanged.
  - Push and pop in the same cycle: both performed, count unchanged. This applies when full too: the pop frees a slot, so the push succeeds with no overflow.
  - Pointers wrap modulo FIFO_DEPTH. The count is stored separately and reaches FIFO_DEPTH.
- irq: registered, irq <= irq_en & non-empty, so it trails a push or pop by 1 cycle.

Test Plan:
- Frame 0x1C (parity 0), CTRL = 3: irq rises; STATUS = 0x101; DATA read = 0x11C; STATUS = 0; irq falls 1 cycle after the pop ack.
- Frame 0x1C with parity 1: FIFO stays empty, STATUS[3] = 1. Write STATUS = 0x8: STATUS = 0. Same flow with stop = 0: STATUS[4] = 1.
- 17 good frames 0x00..0x10, no reads: STATUS full = 1, overflow = 1, count 16. Reads return 0x100..0x10F in order; the 17th read returns 0.
- 5 bits sent, then clock held high for 50000 cycles: framing error set, FSM in IDLE. A following full frame 0xAA is received correctly.
- 2-cycle low glitch on ps2_clk mid-frame: no extra bit sampled, frame received intact. A DATA pop coinciding with a push leaves the count unchanged.
- rstn pulsed low mid-frame with 3 bytes queued: all outputs go to reset values immediately, FIFO empty. The next complete frame is received normally.
